// File: rtl/stream_packet_arbiter.sv
// stream_packet_arbiter
//   Packet-level round-robin arbiter that merges N_REQ AXI-Stream requesters
//   onto one output channel. A grant is held from the header beat through the
//   TLAST beat, so messages never interleave. The header TX_UID byte can be
//   stamped with the granted port's UID. Messages longer than MAX_PKT_WORDS
//   are truncated with a forced TLAST, and their remainder is drained.
//
// Ports
//   clk_200MHz        : only clock
//   peripheral_reset  : synchronous active-high reset
//   s_tdata/s_tvalid/s_tlast/s_tready : requester streams, port i at [i*DATA_W +: DATA_W]
//   m_tdata/m_tvalid/m_tlast/m_tready : merged output stream
//   grant_id          : index of the current or last granted port
//   busy              : high while a message owns the output
//   pkt_count         : completed (or truncated) output messages, wraps
//   oversize_err      : sticky truncation flag, cleared only by reset
module stream_packet_arbiter #(
  parameter int          N_REQ         = 4,
  parameter int          DATA_W        = 32,
  parameter int          MAX_PKT_WORDS = 1024,
  parameter int          STAMP_TX_UID  = 1,
  parameter logic [7:0]  UID_BASE      = 8'h01,
  localparam int         GW            = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                      clk_200MHz,
  input  logic                      peripheral_reset,
  input  logic [N_REQ*DATA_W-1:0]   s_tdata,
  input  logic [N_REQ-1:0]          s_tvalid,
  input  logic [N_REQ-1:0]          s_tlast,
  output logic [N_REQ-1:0]          s_tready,
  output logic [DATA_W-1:0]         m_tdata,
  output logic                      m_tvalid,
  output logic                      m_tlast,
  input  logic                      m_tready,
  output logic [GW-1:0]             grant_id,
  output logic                      busy,
  output logic [15:0]               pkt_count,
  output logic                      oversize_err
);

  localparam int             CW         = (MAX_PKT_WORDS > 1) ? $clog2(MAX_PKT_WORDS) : 1;
  localparam logic [CW-1:0]  CNT_LAST   = CW'(MAX_PKT_WORDS - 1);
  localparam logic [GW-1:0]  GRANT_LAST = GW'(N_REQ - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HEADER  = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_DRAIN   = 2'd3
  } state_t;

  state_t            r_state;
  logic [GW-1:0]     r_grant;
  logic [GW-1:0]     r_last_grant;
  logic [CW-1:0]     r_word_cnt;
  logic [15:0]       r_pkt_count;
  logic              r_oversize_err;

  logic [DATA_W-1:0] w_sel_tdata;
  logic              w_sel_valid;
  logic              w_sel_last;
  logic              w_sel_ready;
  logic              w_accept;
  logic              w_at_cap;

  // Round-robin search starting one past the last grant. Iterating from the
  // farthest candidate down lets the nearest valid port overwrite the pick.
  function automatic logic [GW-1:0] f_rr_pick(input logic [N_REQ-1:0] req,
                                              input logic [GW-1:0]    last);
    logic [GW-1:0] pick;
    int            idx;
    pick = last;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = (int'(last) + k) % N_REQ;
      if (req[idx]) begin
        pick = GW'(idx);
      end
    end
    return pick;
  endfunction

  assign w_sel_tdata = s_tdata[r_grant*DATA_W +: DATA_W];
  assign w_sel_valid = s_tvalid[r_grant];
  assign w_sel_last  = s_tlast[r_grant];
  assign w_at_cap    = (r_word_cnt == CNT_LAST);
  assign w_accept    = w_sel_valid && w_sel_ready;

  assign grant_id     = r_grant;
  assign busy         = (r_state != ST_IDLE);
  assign pkt_count    = r_pkt_count;
  assign oversize_err = r_oversize_err;

  // Combinational pass-through of the granted port; no buffering anywhere.
  always_comb begin
    s_tready    = '0;
    m_tvalid    = 1'b0;
    m_tlast     = 1'b0;
    m_tdata     = '0;
    w_sel_ready = 1'b0;
    case (r_state)
      ST_HEADER, ST_PAYLOAD: begin
        w_sel_ready       = m_tready;
        s_tready[r_grant] = m_tready;
        m_tvalid          = w_sel_valid;
        m_tlast           = w_sel_last || w_at_cap;
        m_tdata           = w_sel_tdata;
        if ((r_state == ST_HEADER) && (STAMP_TX_UID != 0)) begin
          m_tdata[23:16] = UID_BASE + 8'(r_grant);
        end else begin
          m_tdata[23:16] = w_sel_tdata[23:16];
        end
      end
      ST_DRAIN: begin
        // Swallow the rest of a truncated message; output stays silent.
        w_sel_ready       = 1'b1;
        s_tready[r_grant] = 1'b1;
      end
      default: begin
        s_tready = '0;
      end
    endcase
  end

  // Message FSM, grant register, beat counter and status counters.
  always_ff @(posedge clk_200MHz) begin
    if (peripheral_reset) begin
      r_state        <= ST_IDLE;
      r_grant        <= '0;
      r_last_grant   <= GRANT_LAST;
      r_word_cnt     <= '0;
      r_pkt_count    <= 16'd0;
      r_oversize_err <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (|s_tvalid) begin
            r_grant <= f_rr_pick(s_tvalid, r_last_grant);
            r_state <= ST_HEADER;
          end
        end
        ST_HEADER, ST_PAYLOAD: begin
          if (w_accept) begin
            if (w_sel_last) begin
              // A TLAST landing exactly on the cap is a normal end.
              r_state      <= ST_IDLE;
              r_word_cnt   <= '0;
              r_pkt_count  <= r_pkt_count + 16'd1;
              r_last_grant <= r_grant;
            end else if (w_at_cap) begin
              r_state        <= ST_DRAIN;
              r_word_cnt     <= '0;
              r_pkt_count    <= r_pkt_count + 16'd1;
              r_last_grant   <= r_grant;
              r_oversize_err <= 1'b1;
            end else begin
              r_state    <= ST_PAYLOAD;
              r_word_cnt <= r_word_cnt + CW'(1);
            end
          end
        end
        ST_DRAIN: begin
          if (w_accept && w_sel_last) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stream_packet_arbiter.sv
module tb_stream_packet_arbiter;

  localparam int         N    = 4;
  localparam int         DW   = 32;
  localparam int         MAXW = 8;
  localparam logic [7:0] UIDB = 8'h01;
  localparam int         NCYC = 4000;

  logic              clk = 1'b0;
  logic              rst;
  logic [N*DW-1:0]   s_tdata;
  logic [N-1:0]      s_tvalid;
  logic [N-1:0]      s_tlast;
  logic [N-1:0]      s_tready;
  logic [DW-1:0]     m_tdata;
  logic              m_tvalid;
  logic              m_tlast;
  logic              m_tready;
  logic [1:0]        grant_id;
  logic              busy;
  logic [15:0]       pkt_count;
  logic              oversize_err;

  always #5 clk = ~clk;

  stream_packet_arbiter #(
    .N_REQ(N), .DATA_W(DW), .MAX_PKT_WORDS(MAXW), .STAMP_TX_UID(1), .UID_BASE(UIDB)
  ) dut (
    .clk_200MHz(clk), .peripheral_reset(rst),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tready(m_tready),
    .grant_id(grant_id), .busy(busy), .pkt_count(pkt_count), .oversize_err(oversize_err)
  );

  int tests_run = 0;
  int tests_failed = 0;

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Requester side: each port always has one message in flight.
  int          p_len [N];
  int          p_idx [N];
  logic        p_val [N];
  logic [31:0] p_dat [N];

  // Message-level reference: who owns the output and the bookkeeping.
  int          owner;
  int          last_g;
  int          m_grant;
  logic [15:0] m_pkt;
  logic        m_err;

  logic [N-1:0] exp_ready;
  logic         exp_mv;
  logic         exp_ml;
  logic [31:0]  exp_md;
  logic         just_reset;

  function automatic void new_msg(input int i);
    int r;
    r = int'($urandom_range(0, 9));
    if (r == 0)      p_len[i] = 1;
    else if (r < 3)  p_len[i] = int'($urandom_range(MAXW - 1, MAXW + 4));
    else             p_len[i] = int'($urandom_range(2, 6));
    p_idx[i] = 0;
    p_val[i] = 1'b0;
    p_dat[i] = $urandom;
  endfunction

  function automatic void model_reset();
    owner   = -1;
    last_g  = N - 1;
    m_grant = 0;
    m_pkt   = 16'd0;
    m_err   = 1'b0;
    for (int i = 0; i < N; i++) new_msg(i);
  endfunction

  initial begin
    int  g;
    int  ib;
    bit  found;
    bit  was_last;
    rst      = 1'b1;
    s_tdata  = '0;
    s_tvalid = '0;
    s_tlast  = '0;
    m_tready = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    just_reset = 1'b1;

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clk);
      rst = ((cyc == 1500) || (cyc == 3500)) ? 1'b1 : 1'b0;
      for (int i = 0; i < N; i++) begin
        if (!p_val[i] && ($urandom_range(0, 3) != 0)) p_val[i] = 1'b1;
        s_tvalid[i]           = p_val[i];
        s_tdata[i*DW +: DW]   = p_dat[i];
        s_tlast[i]            = (p_idx[i] == p_len[i] - 1);
      end
      if (cyc < 1000)       m_tready = ($urandom_range(0, 3) != 0);
      else if (cyc < 2500)  m_tready = cyc[0];
      else                  m_tready = 1'b1;

      // Expected outputs for this cycle.
      exp_ready = '0;
      exp_mv    = 1'b0;
      exp_ml    = 1'b0;
      exp_md    = 32'h0;
      if (owner >= 0) begin
        g = owner;
        if (p_idx[g] >= MAXW) begin
          exp_ready[g] = 1'b1;
        end else begin
          exp_ready[g] = m_tready;
          exp_mv       = p_val[g];
          exp_md       = p_dat[g];
          if (p_idx[g] == 0) exp_md[23:16] = UIDB + 8'(g);
          exp_ml = (p_idx[g] == p_len[g] - 1) || (p_idx[g] == MAXW - 1);
        end
      end

      #1;
      chk_val("s_tready",  32'(s_tready),     32'(exp_ready));
      chk_val("m_tvalid",  32'(m_tvalid),     32'(exp_mv));
      chk_val("busy",      32'(busy),         32'(owner >= 0));
      chk_val("grant_id",  32'(grant_id),     32'(m_grant));
      chk_val("pkt_count", 32'(pkt_count),    32'(m_pkt));
      chk_val("oversize",  32'(oversize_err), 32'(m_err));
      if (exp_mv) begin
        chk_val("m_tdata", m_tdata,           exp_md);
        chk_val("m_tlast", 32'(m_tlast),      32'(exp_ml));
      end
      if (just_reset) begin
        chk_val("rst_tdata", m_tdata,         32'h0);
        chk_val("rst_tlast", 32'(m_tlast),    32'h0);
        just_reset = 1'b0;
      end

      @(posedge clk);
      if (rst) begin
        model_reset();
        just_reset = 1'b1;
      end else if (owner < 0) begin
        found = 1'b0;
        for (int k = 1; k <= N; k++) begin
          if (!found && p_val[(last_g + k) % N]) begin
            found   = 1'b1;
            owner   = (last_g + k) % N;
            m_grant = owner;
          end
        end
      end else begin
        g = owner;
        if (p_val[g] && exp_ready[g]) begin
          ib       = p_idx[g];
          was_last = (ib == p_len[g] - 1);
          p_idx[g] = ib + 1;
          p_val[g] = 1'b0;
          p_dat[g] = $urandom;
          if (was_last) begin
            if (ib < MAXW) begin
              m_pkt  = m_pkt + 16'd1;
              last_g = g;
            end
            owner = -1;
            new_msg(g);
          end else if (ib == MAXW - 1) begin
            m_pkt  = m_pkt + 16'd1;
            m_err  = 1'b1;
            last_g = g;
          end
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
